// File: rtl/pc_sequencer_if.sv
// Bundle between decoder/regfile, the PC sequencer and instruction memory.
// Optional counter signals exist only when PC_SEQUENCER_PERF_EN is defined.
interface pc_sequencer_if #(
  parameter int XLEN = 32,
  parameter int CNTW = 32
);
  // Stall handshake: stall=1 sampled at a RUN edge freezes iaddr and enters HOLD;
  // the first edge with stall=0 returns to RUN without consuming op, and the
  // instruction still presented is evaluated on the edge after that.
  logic [5:0]      op;
  logic [31:0]     instr;
  logic [XLEN-1:0] rv1;
  logic [XLEN-1:0] rv2;
  logic            stall;
  logic            trap_ack;
  logic [XLEN-1:0] iaddr;
  logic [XLEN-1:0] link;
  logic            taken;
  logic            trap;
  logic [XLEN-1:0] epc;
  logic [1:0]      state;
`ifdef PC_SEQUENCER_PERF_EN
  logic [CNTW-1:0] perf_taken;
  logic [CNTW-1:0] perf_retired;

  modport master (
    output op, instr, rv1, rv2, stall, trap_ack,
    input  iaddr, link, taken, trap, epc, state, perf_taken, perf_retired
  );
  modport slave (
    input  op, instr, rv1, rv2, stall, trap_ack,
    output iaddr, link, taken, trap, epc, state, perf_taken, perf_retired
  );
`else
  modport master (
    output op, instr, rv1, rv2, stall, trap_ack,
    input  iaddr, link, taken, trap, epc, state
  );
  modport slave (
    input  op, instr, rv1, rv2, stall, trap_ack,
    output iaddr, link, taken, trap, epc, state
  );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// RV32I program-counter sequencer: jump/branch resolution, stall HOLD, misaligned trap.
// Define PC_SEQUENCER_PERF_EN to add the retired/taken performance counters.
module pc_sequencer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h100,
  parameter int              CNTW      = 32
) (
  input logic               clk,
  input logic               reset,
  pc_sequencer_if.slave     bus
);
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_TRAP = 2'd2;

  localparam logic [5:0] OP_JAL  = 6'd29;
  localparam logic [5:0] OP_JALR = 6'd30;
  localparam logic [5:0] OP_BEQ  = 6'd31;
  localparam logic [5:0] OP_BNE  = 6'd32;
  localparam logic [5:0] OP_BLT  = 6'd33;
  localparam logic [5:0] OP_BGE  = 6'd34;
  localparam logic [5:0] OP_BLTU = 6'd35;
  localparam logic [5:0] OP_BGEU = 6'd36;

  logic [1:0]      state;
  logic [XLEN-1:0] iaddr;
  logic [XLEN-1:0] epc;
  logic            trap;
  logic [XLEN-1:0] imm_j, imm_i, imm_b;
  logic [XLEN-1:0] seq_pc, npc;
  logic            redirect, taken, misaligned;
  logic            eq, lt_s, lt_u;
  logic            unused_opcode_bits;

  assign imm_j = {{(XLEN-21){bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                  bus.instr[20], bus.instr[30:21], 1'b0};
  assign imm_i = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
  assign imm_b = {{(XLEN-13){bus.instr[31]}}, bus.instr[31], bus.instr[7],
                  bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign unused_opcode_bits = ^bus.instr[6:0];

  assign seq_pc = iaddr + XLEN'(4);
  assign eq     = (bus.rv1 == bus.rv2);
  assign lt_s   = ($signed(bus.rv1) < $signed(bus.rv2));
  assign lt_u   = (bus.rv1 < bus.rv2);

  always_comb begin
    redirect = 1'b0;
    npc      = seq_pc;
    case (bus.op)
      OP_JAL:  begin redirect = 1'b1; npc = iaddr + imm_j; end
      OP_JALR: begin redirect = 1'b1; npc = (bus.rv1 + imm_i) & ~XLEN'(1); end
      OP_BEQ:  redirect = eq;
      OP_BNE:  redirect = !eq;
      OP_BLT:  redirect = lt_s;
      OP_BGE:  redirect = !lt_s;
      OP_BLTU: redirect = lt_u;
      OP_BGEU: redirect = !lt_u;
      default: redirect = 1'b0;
    endcase
    if (redirect && bus.op != OP_JAL && bus.op != OP_JALR) npc = iaddr + imm_b;
  end

  // Only RUN evaluates the presented op; HOLD and TRAP never redirect.
  assign taken      = redirect && (state == ST_RUN);
  assign misaligned = taken && npc[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      iaddr <= RESET_VEC;
      epc   <= '0;
      trap  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.stall) begin
            state <= ST_HOLD;
          end else if (misaligned) begin
            state <= ST_TRAP;
            iaddr <= TRAP_VEC;
            epc   <= iaddr;
            trap  <= 1'b1;
          end else begin
            iaddr <= npc;
          end
        end
        ST_HOLD: if (!bus.stall) state <= ST_RUN;
        ST_TRAP: begin
          if (bus.trap_ack) begin
            state <= ST_RUN;
            trap  <= 1'b0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef PC_SEQUENCER_PERF_EN
  logic [CNTW-1:0] perf_taken, perf_retired;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_taken   <= '0;
      perf_retired <= '0;
    end else if (state == ST_RUN && !bus.stall && !misaligned) begin
      perf_retired <= perf_retired + CNTW'(1);
      if (taken) perf_taken <= perf_taken + CNTW'(1);
    end
  end

  assign bus.perf_taken   = perf_taken;
  assign bus.perf_retired = perf_retired;
`endif

  assign bus.iaddr = iaddr;
  assign bus.link  = seq_pc;
  assign bus.taken = taken;
  assign bus.trap  = trap;
  assign bus.epc   = epc;
  assign bus.state = state;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for single-edge behaviour,
// hand sequences for stall dwell, reset in HOLD/TRAP and the optional counters.
module tb_pc_sequencer;
  localparam logic [5:0] JAL = 6'd29, JALR = 6'd30, BEQ = 6'd31, BNE = 6'd32;
  localparam logic [5:0] BLT = 6'd33, BGE = 6'd34, BLTU = 6'd35, BGEU = 6'd36;
  localparam logic [1:0] S_RUN = 2'd0, S_HOLD = 2'd1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] exp_q[$];

  pc_sequencer_if #(.XLEN(32), .CNTW(32)) bus ();

  pc_sequencer #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .CNTW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] instr;
    logic [31:0] rv1;
    logic [31:0] rv2;
    logic        stall;
    logic        ack;
    logic        exp_taken;
    logic [31:0] exp_link;
    logic [31:0] exp_iaddr;
    logic        exp_trap;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc_b(input int off);
    logic [12:0] o;
    o = off[12:0];
    return {o[12], o[10:5], 13'd0, o[4:1], o[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int off);
    logic [20:0] o;
    o = off[20:0];
    return {o[20], o[10:1], o[11], o[19:12], 12'h06f};
  endfunction

  function automatic logic [31:0] enc_i(input int imm);
    logic [11:0] o;
    o = imm[11:0];
    return {o, 20'h00067};
  endfunction

  function automatic vec_t mk(input string name, input logic [5:0] op, input logic [31:0] instr,
                              input logic [31:0] rv1, input logic [31:0] rv2, input logic stall,
                              input logic ack, input logic exp_taken, input logic [31:0] exp_link,
                              input logic [31:0] exp_iaddr, input logic exp_trap,
                              input logic [31:0] exp_epc);
    vec_t v;
    v.name = name; v.op = op; v.instr = instr; v.rv1 = rv1; v.rv2 = rv2;
    v.stall = stall; v.ack = ack; v.exp_taken = exp_taken; v.exp_link = exp_link;
    v.exp_iaddr = exp_iaddr; v.exp_trap = exp_trap; v.exp_epc = exp_epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] instr, input logic [31:0] rv1,
                       input logic [31:0] rv2, input logic stall, input logic ack);
    bus.op = op; bus.instr = instr; bus.rv1 = rv1; bus.rv2 = rv2;
    bus.stall = stall; bus.trap_ack = ack;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_check(input string name);
    logic [31:0] e;
    step();
    e = exp_q.pop_front();
    check(name, bus.iaddr, e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(6'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    drive(6'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
    check("reset_iaddr", bus.iaddr, 32'h0);
    check("reset_trap", {31'd0, bus.trap}, 32'd0);
    check("reset_epc", bus.epc, 32'h0);
    check("reset_state", {30'd0, bus.state}, {30'd0, S_RUN});
`ifdef PC_SEQUENCER_PERF_EN
    check("reset_perf_retired", bus.perf_retired, 32'd0);
    check("reset_perf_taken", bus.perf_taken, 32'd0);
`endif

    vecs.push_back(mk("seq0",  6'd0, 32'h0, 0, 0, 0, 0, 0, 32'h04, 32'h04, 0, 0));
    vecs.push_back(mk("seq1",  6'd0, 32'h0, 0, 0, 0, 0, 0, 32'h08, 32'h08, 0, 0));
    vecs.push_back(mk("seq2",  6'd0, 32'h0, 0, 0, 0, 0, 0, 32'h0c, 32'h0c, 0, 0));
    vecs.push_back(mk("seq3",  6'd0, 32'h0, 0, 0, 0, 0, 0, 32'h10, 32'h10, 0, 0));
    vecs.push_back(mk("seq4",  6'd5, 32'h0, 0, 0, 0, 0, 0, 32'h14, 32'h14, 0, 0));
    vecs.push_back(mk("seq5",  6'd0, 32'h0, 0, 0, 0, 0, 0, 32'h18, 32'h18, 0, 0));
    vecs.push_back(mk("seq6",  6'd0, 32'h0, 0, 0, 0, 0, 0, 32'h1c, 32'h1c, 0, 0));
    vecs.push_back(mk("seq7",  6'd0, 32'h0, 0, 0, 0, 0, 0, 32'h20, 32'h20, 0, 0));
    vecs.push_back(mk("beq_back", BEQ, enc_b(-16), 5, 5, 0, 0, 1, 32'h24, 32'h10, 0, 0));
    vecs.push_back(mk("bltu_nt", BLTU, enc_b(8), 32'hffffffff, 1, 0, 0, 0, 32'h14, 32'h14, 0, 0));
    vecs.push_back(mk("blt_t", BLT, enc_b(12), 32'hffffffff, 1, 0, 0, 1, 32'h18, 32'h20, 0, 0));
    vecs.push_back(mk("bne_nt", BNE, enc_b(64), 3, 3, 0, 0, 0, 32'h24, 32'h24, 0, 0));
    vecs.push_back(mk("bge_t", BGE, enc_b(28), 1, 32'hffffffff, 0, 0, 1, 32'h28, 32'h40, 0, 0));
    vecs.push_back(mk("bgeu_nt", BGEU, enc_b(28), 1, 32'hffffffff, 0, 0, 0, 32'h44, 32'h44, 0, 0));
    vecs.push_back(mk("jal", JAL, enc_j(32'h3c), 0, 0, 0, 0, 1, 32'h48, 32'h80, 0, 0));
    vecs.push_back(mk("jalr_bit0", JALR, enc_i(32'h10), 32'h1f1, 0, 0, 0, 1, 32'h84, 32'h200, 0, 0));
    vecs.push_back(mk("jalr_mis", JALR, enc_i(0), 32'h203, 0, 0, 0, 1, 32'h204, 32'h100, 1, 32'h200));
    vecs.push_back(mk("trap_hold", JAL, enc_j(32'h40), 0, 0, 1, 0, 0, 32'h104, 32'h100, 1, 32'h200));
    vecs.push_back(mk("trap_ack", JAL, enc_j(32'h40), 0, 0, 0, 1, 0, 32'h104, 32'h100, 0, 32'h200));
    vecs.push_back(mk("handler0", 6'd0, 32'h0, 0, 0, 0, 0, 0, 32'h104, 32'h104, 0, 32'h200));
    vecs.push_back(mk("beq_mis", BEQ, enc_b(6), 3, 3, 0, 0, 1, 32'h108, 32'h100, 1, 32'h104));
    vecs.push_back(mk("trap_ack2", 6'd0, 32'h0, 0, 0, 0, 1, 0, 32'h104, 32'h100, 0, 32'h104));
    vecs.push_back(mk("stray_ack", 6'd0, 32'h0, 0, 0, 0, 1, 0, 32'h104, 32'h104, 0, 32'h104));

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].instr, vecs[i].rv1, vecs[i].rv2, vecs[i].stall, vecs[i].ack);
      #1;
      check({vecs[i].name, "_taken"}, {31'd0, bus.taken}, {31'd0, vecs[i].exp_taken});
      check({vecs[i].name, "_link"}, bus.link, vecs[i].exp_link);
      step();
      check({vecs[i].name, "_iaddr"}, bus.iaddr, vecs[i].exp_iaddr);
      check({vecs[i].name, "_trap"}, {31'd0, bus.trap}, {31'd0, vecs[i].exp_trap});
      check({vecs[i].name, "_epc"}, bus.epc, vecs[i].exp_epc);
    end

    // Stall: three HOLD edges plus the release edge keep 0x8, then the JAL lands.
    do_reset();
    exp_q = '{32'h4, 32'h8, 32'h8, 32'h8, 32'h8, 32'h8, 32'h48};
    step_check("stall_pre0");
    step_check("stall_pre1");
    drive(JAL, enc_j(32'h40), 0, 0, 1'b1, 1'b0);
    #1;
    check("stall_taken_run", {31'd0, bus.taken}, 32'd1);
    step_check("stall_e1");
    check("stall_state_hold", {30'd0, bus.state}, {30'd0, S_HOLD});
    check("stall_taken_hold", {31'd0, bus.taken}, 32'd0);
    step_check("stall_e2");
    step_check("stall_e3");
    bus.stall = 1'b0;
    step_check("stall_release");
    check("stall_state_run", {30'd0, bus.state}, {30'd0, S_RUN});
    check("stall_link", bus.link, 32'h0c);
    step_check("stall_target");
    check("stall_q_empty", exp_q.size(), 32'd0);

    // Reset while in HOLD.
    drive(6'd0, 32'h0, 0, 0, 1'b1, 1'b0);
    step();
    check("hold_before_reset", {30'd0, bus.state}, {30'd0, S_HOLD});
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("hold_reset_iaddr", bus.iaddr, 32'h0);
    check("hold_reset_state", {30'd0, bus.state}, {30'd0, S_RUN});
    check("hold_reset_trap", {31'd0, bus.trap}, 32'd0);

    // Reset while in TRAP, with a non-zero epc captured first.
    drive(6'd0, 32'h0, 0, 0, 1'b0, 1'b0);
    step();
    drive(JALR, enc_i(0), 32'h2, 0, 1'b0, 1'b0);
    step();
    check("trap2_trap", {31'd0, bus.trap}, 32'd1);
    check("trap2_epc", bus.epc, 32'h4);
    check("trap2_iaddr", bus.iaddr, 32'h100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("trap_reset_iaddr", bus.iaddr, 32'h0);
    check("trap_reset_trap", {31'd0, bus.trap}, 32'd0);
    check("trap_reset_epc", bus.epc, 32'h0);
    check("trap_reset_state", {30'd0, bus.state}, {30'd0, S_RUN});

`ifdef PC_SEQUENCER_PERF_EN
    // Ten retiring instructions, three taken, two stall cycles.
    do_reset();
    drive(6'd0, 32'h0, 0, 0, 1'b0, 1'b0); step();
    drive(6'd0, 32'h0, 0, 0, 1'b0, 1'b0); step();
    drive(BEQ, enc_b(8), 7, 7, 1'b0, 1'b0); step();
    drive(6'd0, 32'h0, 0, 0, 1'b1, 1'b0); step();
    bus.stall = 1'b0; step();
    step();
    drive(JAL, enc_j(8), 0, 0, 1'b0, 1'b0); step();
    drive(6'd0, 32'h0, 0, 0, 1'b0, 1'b0); step();
    drive(BNE, enc_b(8), 4, 4, 1'b1, 1'b0); step();
    bus.stall = 1'b0; step();
    step();
    drive(BLT, enc_b(8), 32'hffffffff, 1, 1'b0, 1'b0); step();
    drive(6'd0, 32'h0, 0, 0, 1'b0, 1'b0); step();
    step();
    check("perf_iaddr", bus.iaddr, 32'd52);
    check("perf_retired", bus.perf_retired, 32'd10);
    check("perf_taken", bus.perf_taken, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
